// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: one req/ack bus transaction per instruction, stalling the pipe.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and complete with Misalign=1.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] RdData,
  output logic        Misalign,
  output logic        BusErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        req;
  logic        trap;
  logic [3:0]  be_d;
  logic [31:0] wd_d;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign req = MemRead | MemWrite;

  // Gated by reset so a pipeline held in reset never sees a stall.
  assign Stall = !reset && (((state == IDLE) && req) || (state == BUS));
  assign Done  = (state == DONE);

  always_comb begin
    be_d = 4'b1111;
    wd_d = WrData;
    unique case (Funct3)
      3'b000, 3'b100: begin
        be_d = 4'b0001 << Addr[1:0];
        wd_d = {4{WrData[7:0]}};
      end
      3'b001, 3'b101: begin
        be_d = 4'b0011 << {Addr[1], 1'b0};
        wd_d = {2{WrData[15:0]}};
      end
      default: begin
        be_d = 4'b1111;
        wd_d = WrData;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_d;
  logic mis_q;

  always_comb begin
    mis_d = 1'b0;
    if ((Funct3[1:0] == 2'b01) && Addr[0]) mis_d = 1'b1;
    if ((Funct3 == 3'b010) && (Addr[1:0] != 2'b00)) mis_d = 1'b1;
  end

  assign trap     = mis_d;
  assign Misalign = mis_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else if ((state == IDLE) && req) begin
      mis_q <= mis_d;
    end
  end
`else
  assign trap     = 1'b0;
  assign Misalign = 1'b0;
`endif

  // Halves use only Addr[1]; a misaligned half falls back to its aligned lane.
  assign shifted = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = bus_rdata;
    unique case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = off_q[1] ? {{16{bus_rdata[31]}}, bus_rdata[31:16]}
                                    : {{16{bus_rdata[15]}}, bus_rdata[15:0]};
      3'b101:  load_data = off_q[1] ? {16'd0, bus_rdata[31:16]} : {16'd0, bus_rdata[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      RdData    <= 32'd0;
      BusErr    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            f3_q      <= Funct3;
            off_q     <= Addr[1:0];
            bus_addr  <= {Addr[31:2], 2'b00};
            bus_we    <= MemWrite;
            bus_be    <= be_d;
            bus_wdata <= wd_d;
            cnt       <= 8'd0;
            BusErr    <= 1'b0;
            if (trap) begin
              state  <= DONE;
              RdData <= 32'd0;
            end else begin
              state   <= BUS;
              bus_req <= 1'b1;
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            RdData  <= load_data;
          end else if (cnt == TO_LAST) begin
            state   <= DONE;
            bus_req <= 1'b0;
            BusErr  <= 1'b1;
            RdData  <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a bus-responder loop and a result scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WrData;
  logic        Stall, Done, Misalign, BusErr;
  logic [31:0] RdData;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        err;
    int          lat;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .Addr(Addr), .WrData(WrData), .Stall(Stall), .Done(Done), .RdData(RdData),
    .Misalign(Misalign), .BusErr(BusErr), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one access starting in an IDLE cycle; ack_k = BUS cycle of ack, 0 = never ack.
  task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                        input int ack_k, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input bit e_we, input int e_buscyc,
                        input exp_t e);
    int cyc = 0;
    int busc = 0;
    bit fin = 0;
    exp_t got;
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
    sb.push_back(e);
    #1 chk({tag, " stall@T"}, 32'(Stall), 32'd1);
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      if (Done) begin
        fin = 1;
        MemRead = 0; MemWrite = 0; bus_ack = 0;
        chk({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk({tag, " latency"}, 32'(cyc), 32'(got.lat));
          if (got.chk_rd) chk({tag, " rddata"}, RdData, got.rd);
          chk({tag, " misalign"}, 32'(Misalign), 32'(got.mis));
          chk({tag, " buserr"}, 32'(BusErr), 32'(got.err));
        end
        chk({tag, " bus_cycles"}, 32'(busc), 32'(e_buscyc));
        chk({tag, " stall@done"}, 32'(Stall), 32'd0);
        chk({tag, " req@done"}, 32'(bus_req), 32'd0);
      end else if (cyc > 20) begin
        fin = 1;
        MemRead = 0; MemWrite = 0; bus_ack = 0;
        chk({tag, " done_timeout"}, 32'(cyc), 32'(e.lat));
      end else begin
        chk({tag, " stall"}, 32'(Stall), 32'd1);
        if (bus_req) begin
          busc++;
          chk({tag, " bus_addr"}, bus_addr, e_addr);
          chk({tag, " bus_be"}, 32'(bus_be), 32'(e_be));
          chk({tag, " bus_we"}, 32'(bus_we), 32'(e_we));
          if (e_we) chk({tag, " bus_wdata"}, bus_wdata, e_wd);
        end
        bus_rdata = rdata;
        bus_ack = (ack_k != 0) && (cyc == ack_k);
      end
    end
    @(posedge clk); #1;
    chk({tag, " req@idle"}, 32'(bus_req), 32'd0);
    chk({tag, " done@idle"}, 32'(Done), 32'd0);
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic mis, input logic err,
                              input int lat, input bit chk_rd);
    exp_t e;
    e.rd = rd; e.mis = mis; e.err = err; e.lat = lat; e.chk_rd = chk_rd;
    return e;
  endfunction

  initial begin
    reset = 1; MemRead = 0; MemWrite = 0; Funct3 = 0; Addr = 0; WrData = 0;
    bus_ack = 0; bus_rdata = 0;
    #12;
    chk("rst stall", 32'(Stall), 32'd0);
    chk("rst done", 32'(Done), 32'd0);
    chk("rst rddata", RdData, 32'd0);
    chk("rst flags", {30'd0, Misalign, BusErr}, 32'd0);
    chk("rst req_we", {30'd0, bus_req, bus_we}, 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_be", 32'(bus_be), 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'd0);
    @(posedge clk); #1 reset = 0;

    access("lw0", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1, 32'h100, 4'b1111, 0, 0, 1,
           mk(32'hDEADBEEF, 0, 0, 2, 1));
    access("lb", 1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 2, 32'h100, 4'b1000, 0, 0, 2,
           mk(32'hFFFFFF80, 0, 0, 3, 1));
    access("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 1, 32'h100, 4'b1000, 0, 0, 1,
           mk(32'h00000080, 0, 0, 2, 1));
    access("sh", 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 4, 32'h200, 4'b1100, 32'hABCDABCD,
           1, 4, mk(0, 0, 0, 5, 0));
    access("tmo", 1, 0, 3'b010, 32'h300, 0, 32'h55555555, 0, 32'h300, 4'b1111, 0, 0, 4,
           mk(32'h0, 0, 1, 5, 1));
`ifdef MISALIGN_TRAP_EN
    access("lw_mis", 1, 0, 3'b010, 32'h102, 0, 32'h11223344, 1, 32'h100, 4'b1111, 0, 0, 0,
           mk(32'h0, 1, 0, 1, 1));
`else
    access("lw_mis", 1, 0, 3'b010, 32'h102, 0, 32'h11223344, 1, 32'h100, 4'b1111, 0, 0, 1,
           mk(32'h11223344, 0, 0, 2, 1));
`endif
    access("lh", 1, 0, 3'b001, 32'h106, 0, 32'h80017FFF, 1, 32'h104, 4'b1100, 0, 0, 1,
           mk(32'hFFFF8001, 0, 0, 2, 1));
    access("lhu", 1, 0, 3'b101, 32'h104, 0, 32'h80017FFF, 3, 32'h104, 4'b0011, 0, 0, 3,
           mk(32'h00007FFF, 0, 0, 4, 1));
    access("sb", 0, 1, 3'b000, 32'h201, 32'h000000A5, 0, 1, 32'h200, 4'b0010, 32'hA5A5A5A5,
           1, 1, mk(0, 0, 0, 2, 0));
    access("both", 1, 1, 3'b010, 32'h400, 32'hCAFEF00D, 0, 2, 32'h400, 4'b1111, 32'hCAFEF00D,
           1, 2, mk(0, 0, 0, 3, 0));

    // Abort mid-transaction, then show a late ack is ignored.
    MemRead = 1; Funct3 = 3'b010; Addr = 32'h500;
    @(posedge clk); #1;
    chk("abort req_up", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    MemRead = 0;
    #1 reset = 1;
    #1;
    chk("abort req", 32'(bus_req), 32'd0);
    chk("abort stall", 32'(Stall), 32'd0);
    chk("abort done", 32'(Done), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    bus_ack = 1; bus_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("late_ack done", 32'(Done), 32'd0);
      chk("late_ack req", 32'(bus_req), 32'd0);
    end
    bus_ack = 0;

    access("recover", 1, 0, 3'b010, 32'h600, 0, 32'h0BADF00D, 1, 32'h600, 4'b1111, 0, 0, 1,
           mk(32'h0BADF00D, 0, 0, 2, 1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store responder for the five-stage RISC-V pipeline. It consumes the MemRead/MemWrite strobes and funct3 produced by decode, runs one transaction per instruction on a variable-latency req/ack data-memory bus, and stalls the pipeline until the access completes. It generates byte enables and lane-replicated store data. For loads it returns aligned, sign- or zero-extended data for write-back.

## Interface
Parameters:
- TIMEOUT_CYC, 255: maximum cycles in BUS state without bus_ack before a bus error is reported; range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request from the pipeline (held while Stall=1).
- MemWrite  in  1  store request (held while Stall=1).
- Funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- Addr  in  32  byte address from the ALU.
- WrData  in  32  store data (rs2).
- Stall  out  1  pipeline freeze request.
- Done  out  1  one-cycle completion pulse.
- RdData  out  32  load result; valid only when Done=1.
- Misalign  out  1  misaligned access flag; valid only when Done=1.
- BusErr  out  1  timeout flag; valid only when Done=1.
- bus_req  out  1  memory request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, {Addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  memory completion; sampled only while bus_req=1.
- bus_rdata  in  32  read word; valid with bus_ack.

## Operation
- FSM states are IDLE, BUS and DONE.
- IDLE:
  - On MemRead|MemWrite, Stall=1 combinationally in the same cycle.
  - The unit latches Addr, Funct3 and WrData.
  - If both strobes are high, the access is a write.
  - Next state is BUS, or DONE on a trapped misalignment.
- BUS:
  - bus_req=1 (registered).
  - bus_addr, bus_we, bus_be and bus_wdata are held stable.
  - The timeout counter increments each cycle.
  - bus_ack=1 -> DONE, capturing bus_rdata.
  - If the counter reaches TIMEOUT_CYC with no ack -> DONE with BusErr=1, RdData=0.
- DONE: Done=1, Stall=0, then IDLE. Inputs seen in the following IDLE cycle belong to the next instruction.
- Byte enables, where o=Addr[1:0]:
  - b: 4'b0001<<o.
  - h: 4'b0011<<{o[1],1'b0}.
  - w and any other Funct3: 4'b1111.
- Store data:
  - b: byte replicated ×4.
  - h: halfword ×2.
  - w: unchanged.
- Load extraction:
  - lb/lbu: byte at lane o, sign-/zero-extended.
  - lh/lhu: half at Addr[1], sign-/zero-extended.
  - lw and any undefined Funct3: full word.
- Misalignment: a half access with o[0]=1, or a word access with o!=0.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - Stall, Done, RdData, Misalign, BusErr all 0.
  - bus_req, bus_we, bus_addr, bus_be, bus_wdata all 0.
- reset mid-transaction drops bus_req asynchronously. A late bus_ack is ignored.
- Zero-wait memory (ack in the first BUS cycle):
  - Request cycle T (Stall=1), BUS at T+1 (Stall=1), DONE at T+2.
  - Total 2 stall cycles.
- With ack in BUS cycle k (k≥1), Done is asserted at cycle T+k+1.
- bus_req deasserts in the cycle after bus_ack is sampled. Back-to-back accesses therefore have bus_req low for at least 2 cycles (DONE, IDLE).
- bus_ack while bus_req=0 is ignored.
- Timeout: Done at T+TIMEOUT_CYC+1.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned access issues no bus transaction: IDLE -> DONE directly, 1 stall cycle.
  - Done=1, Misalign=1, RdData=0.
- MISALIGN_TRAP_EN undefined:
  - Misalign is tied 0.
  - Misaligned accesses proceed using the aligned lanes given above, i.e. offset bits that violate alignment are ignored.

## Test plan
- Zero-wait lw, Addr=0x100, bus_rdata=0xDEADBEEF, ack at the first BUS cycle -> bus_be=1111, Stall high 2 cycles, Done with RdData=0xDEADBEEF.
- lb at 0x103 and lbu at 0x103, bus_rdata=0x80FF0000:
  - lb -> bus_be=1000, RdData=0xFFFFFF80.
  - lbu -> RdData=0x00000080.
- sh at 0x202, WrData=0x1234ABCD, ack after 3 wait cycles -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD stable until ack, Done 5 cycles after request.
- No ack, TIMEOUT_CYC=4 -> bus_req high 4 cycles, then Done with BusErr=1, RdData=0.
- lw at 0x102:
  - With MISALIGN_TRAP_EN -> no bus_req, Done next cycle, Misalign=1.
  - Without MISALIGN_TRAP_EN -> bus_addr=0x100, be=1111, Misalign=0.
- Assert reset during BUS -> bus_req, Stall, Done all 0 immediately. A subsequent bus_ack causes no Done.
